// File: rtl/tdc_multi_if.sv
// Record stream from the TDC FIFO head to the downstream correlation logic.
// Show-ahead valid/ready: data is meaningful whenever out_valid is high.
interface tdc_multi_if #(
   parameter int NCH   = 2,
   parameter int CNT_W = 8
);
   logic             out_valid;
   logic             out_ready;
   logic [NCH-1:0]   out_start_mask;
   logic [NCH-1:0]   out_end_mask;
   logic [CNT_W-1:0] out_interval;

   modport master (
      output out_valid,
      output out_start_mask,
      output out_end_mask,
      output out_interval,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_start_mask,
      input  out_end_mask,
      input  out_interval,
      output out_ready
   );
endinterface

// File: rtl/tdc_multi.sv
// Multi-channel coarse TDC: rising-edge events on NCH pulse inputs are timed
// against the previous event and queued as {start_mask, end_mask, interval}.
module tdc_multi #(
   parameter int NCH   = 2,
   parameter int CNT_W = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [NCH-1:0]           pulse_in,
   tdc_multi_if.master              rec_if,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              drop_count
);
   localparam int AW    = $clog2(DEPTH);
   localparam int REC_W = 2 * NCH + CNT_W;
   localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
   localparam logic [AW:0]      FULL = (AW + 1)'(DEPTH);

   logic [NCH-1:0]   pulse_q;
   logic [NCH-1:0]   last_mask;
   logic [NCH-1:0]   pulse_rise;
   logic [CNT_W-1:0] cnt;
   logic             evt;
   logic             coinc;
   logic             armed;
   logic             rec_vld;
   logic             push;
   logic             pop;
   logic             drop;
   logic [REC_W-1:0] rec;
   logic [REC_W-1:0] head;
   logic [REC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_comb begin
      pulse_rise = pulse_in & ~pulse_q;
      evt        = en & (|pulse_rise);
      coinc      = $countones(pulse_rise) > 1;
      armed      = cnt != MAX;
      rec_vld    = evt & (coinc | armed);
      // Coincident edges carry no meaningful interval, so report zero.
      rec        = coinc ? {pulse_rise, pulse_rise, {CNT_W{1'b0}}}
                         : {last_mask, pulse_rise, cnt};
      pop        = rec_if.out_valid & rec_if.out_ready;
      push       = rec_vld & ((fifo_level < FULL) | pop);
      drop       = rec_vld & ~push;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_q   <= '0;
         cnt       <= MAX;
         last_mask <= '0;
      end else begin
         pulse_q <= pulse_in;
         if (!en) begin
            cnt <= MAX;
         end else if (evt) begin
            cnt       <= CNT_W'(1);
            last_mask <= pulse_rise;
         end else if (cnt != MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         drop_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
            2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   assign rec_if.out_valid = fifo_level != '0;
   assign head             = rec_if.out_valid ? mem[rd_ptr] : '0;

   assign rec_if.out_start_mask = head[REC_W-1 -: NCH];
   assign rec_if.out_end_mask   = head[CNT_W +: NCH];
   assign rec_if.out_interval   = head[CNT_W-1:0];
endmodule
